hs_fifo_sfifo_rd_stream: RTL and testbench

- Read-side consumer for the team's synchronous FIFO.
- Drives the FIFO read port (rd_en/empty/rd_data, optional last) and re-presents the words as a valid/ready stream with full throughput.
- Hides the FIFO read latency, which is 1 cycle, or 2 cycles when the FIFO output register is enabled, using a credit-managed elastic buffer.
- Sits between an hs_fifo_sfifo instance and any downstream stream consumer; also provides a flush for error recovery.

---
 rtl/hs_fifo_sfifo_rd_stream.sv | 127 ++++++++++++
 tb/tb_hs_fifo_sfifo_rd_stream.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_fifo_sfifo_rd_stream.sv
// Read-side consumer for hs_fifo_sfifo: hides the 1/2-cycle FIFO read latency behind a credit-managed elastic buffer.
// Optional pkt_cnt_o output enabled by `HS_FIFO_SFIFO_RD_STREAM_PKT_CNT_EN.
module hs_fifo_sfifo_rd_stream #(
  parameter int DATA_WIDTH     = 16,
  parameter int RD_LATENCY     = 1,
  parameter int EN_LAST_SIGNAL = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty_i,
  output logic                  fifo_rd_en_o,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
  input  logic                  fifo_rd_last_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o,
  input  logic                  flush_i,
  output logic                  flush_busy_o
`ifdef HS_FIFO_SFIFO_RD_STREAM_PKT_CNT_EN
  ,
  output logic [31:0]           pkt_cnt_o
`endif
);

  localparam int  BUF_DEPTH = RD_LATENCY + 1;
  localparam int  PTR_W     = (BUF_DEPTH > 2) ? $clog2(BUF_DEPTH) : 1;
  localparam int  CNT_W     = $clog2(BUF_DEPTH + 1);
  localparam int  SUM_W     = CNT_W + 1;
  localparam bit  KEEP_LAST = (EN_LAST_SIGNAL != 0);

  generate
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
      $error("hs_fifo_sfifo_rd_stream: RD_LATENCY must be 1 or 2");
    end
  endgenerate

  typedef enum logic {RUN, FLUSH} state_t;

  state_t                state, state_nxt;
  logic [RD_LATENCY-1:0] pipe, pipe_nxt;
  logic [DATA_WIDTH-1:0] buf_data [BUF_DEPTH];
  logic                  buf_last [BUF_DEPTH];
  logic [PTR_W-1:0]      head, tail;
  logic [CNT_W-1:0]      count, inflight;
  logic [SUM_W-1:0]      credit_used;
  logic                  token_out, push, pop, run;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + CNT_W'(pipe[i]);
  end

  generate
    if (RD_LATENCY == 1) begin : g_pipe1
      assign pipe_nxt = fifo_rd_en_o;
    end else begin : g_pipen
      assign pipe_nxt = {pipe[RD_LATENCY-2:0], fifo_rd_en_o};
    end
  endgenerate

  assign run          = (state == RUN);
  assign token_out    = pipe[RD_LATENCY-1];
  assign m_valid_o    = (count != '0) && run;
  assign pop          = m_valid_o && m_ready_i;
  // A returning word is dropped if the flush lands in the same cycle it arrives.
  assign push         = token_out && run && !flush_i;
  assign credit_used  = SUM_W'(inflight) + SUM_W'(count) - SUM_W'(pop);
  assign fifo_rd_en_o = rst_n && run && !fifo_empty_i && !flush_i &&
                        (credit_used < SUM_W'(BUF_DEPTH));
  assign m_data_o     = buf_data[head];
  assign m_last_o     = buf_last[head];
  assign flush_busy_o = (state == FLUSH);

  // FLUSH exit looks at the registered pipe, i.e. the tokens left after the previous shift.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (flush_i) state_nxt = FLUSH;
      FLUSH:   if (inflight == '0) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      pipe  <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_data[i] <= '0;
        buf_last[i] <= 1'b0;
      end
    end else begin
      state <= state_nxt;
      pipe  <= pipe_nxt;
      if (run && flush_i) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) begin
          buf_data[tail] <= fifo_rd_data_i;
          buf_last[tail] <= fifo_rd_last_i && KEEP_LAST;
          tail           <= ptr_inc(tail);
        end
        if (pop) head <= ptr_inc(head);
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

`ifdef HS_FIFO_SFIFO_RD_STREAM_PKT_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                   pkt_cnt_o <= '0;
    else if (flush_i)             pkt_cnt_o <= '0;
    else if (pop && m_last_o)     pkt_cnt_o <= pkt_cnt_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_hs_fifo_sfifo_rd_stream.sv
// Bench for hs_fifo_sfifo_rd_stream: one RD_LATENCY=1 instance (last enabled) and one RD_LATENCY=2 instance (last disabled).
module tb_hs_fifo_sfifo_rd_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  rd_en, empty, m_valid, m_ready, m_last, flush, busy;
  logic [15:0] m_data0, m_data1;
  logic [15:0] rdata0 = '0, rdata1 = '0;
  logic        rlast0 = 1'b0, rlast1 = 1'b0;
  logic [16:0] d1_1 = '0;
`ifdef HS_FIFO_SFIFO_RD_STREAM_PKT_CNT_EN
  logic [31:0] pkt_cnt0, pkt_cnt1;
`endif

  // Behavioural FIFOs: {last, data} words, registered empty, latency 1 / 2.
  logic [16:0] fmem0 [128];
  logic [16:0] fmem1 [128];
  logic [6:0]  wr_ptr0 = '0, wr_ptr1 = '0, rd_ptr0 = '0, rd_ptr1 = '0;
  assign empty[0] = (rd_ptr0 == wr_ptr0);
  assign empty[1] = (rd_ptr1 == wr_ptr1);

  always @(posedge clk) begin
    if (rd_en[0] === 1'b1) begin
      {rlast0, rdata0} <= fmem0[rd_ptr0];
      rd_ptr0 <= rd_ptr0 + 7'd1;
    end
    if (rd_en[1] === 1'b1) begin
      d1_1    <= fmem1[rd_ptr1];
      rd_ptr1 <= rd_ptr1 + 7'd1;
    end
    {rlast1, rdata1} <= d1_1;
  end

  hs_fifo_sfifo_rd_stream #(.DATA_WIDTH(16), .RD_LATENCY(1), .EN_LAST_SIGNAL(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .fifo_empty_i(empty[0]), .fifo_rd_en_o(rd_en[0]),
    .fifo_rd_data_i(rdata0), .fifo_rd_last_i(rlast0), .m_valid_o(m_valid[0]),
    .m_ready_i(m_ready[0]), .m_data_o(m_data0), .m_last_o(m_last[0]),
    .flush_i(flush[0]), .flush_busy_o(busy[0])
`ifdef HS_FIFO_SFIFO_RD_STREAM_PKT_CNT_EN
    , .pkt_cnt_o(pkt_cnt0)
`endif
  );

  hs_fifo_sfifo_rd_stream #(.DATA_WIDTH(16), .RD_LATENCY(2), .EN_LAST_SIGNAL(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .fifo_empty_i(empty[1]), .fifo_rd_en_o(rd_en[1]),
    .fifo_rd_data_i(rdata1), .fifo_rd_last_i(rlast1), .m_valid_o(m_valid[1]),
    .m_ready_i(m_ready[1]), .m_data_o(m_data1), .m_last_o(m_last[1]),
    .flush_i(flush[1]), .flush_busy_o(busy[1])
`ifdef HS_FIFO_SFIFO_RD_STREAM_PKT_CNT_EN
    , .pkt_cnt_o(pkt_cnt1)
`endif
  );

  int tests = 0, fails = 0;
  int rd_cnt [2] = '{0, 0};
  int pop_cnt[2] = '{0, 0};
  logic [16:0] q0[$], q1[$];

  typedef struct {
    bit          rdy;
    bit          exp_rd;
    bit          exp_vld;
    logic [15:0] exp_dat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int qsize(input int g);
    return (g == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [15:0] sdata(input int g);
    return (g == 0) ? m_data0 : m_data1;
  endfunction

  task automatic load(input int g, input logic [15:0] d, input bit last);
    if (g == 0) begin
      fmem0[wr_ptr0] = {last, d};
      wr_ptr0 = wr_ptr0 + 7'd1;
      q0.push_back({last, d});
    end else begin
      fmem1[wr_ptr1] = {last, d};
      wr_ptr1 = wr_ptr1 + 7'd1;
      q1.push_back({1'b0, d});
    end
  endtask

  // Negedge sample: scoreboard, credit bound, read/pop bookkeeping.
  task automatic sample();
    logic [16:0] e;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("credit_bound%0d", g), 32'(rd_cnt[g] - pop_cnt[g] <= g + 2), 32'd1);
      if (m_valid[g] === 1'b1 && m_ready[g] === 1'b1) begin
        pop_cnt[g]++;
        if (qsize(g) == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_extra%0d: got word 0x%0h, expected none", g, sdata(g));
        end else begin
          if (g == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          check($sformatf("sb_data%0d", g), 32'(sdata(g)), 32'(e[15:0]));
          check($sformatf("sb_last%0d", g), 32'(m_last[g]), 32'(e[16]));
        end
      end
      if (rd_en[g] === 1'b1) rd_cnt[g]++;
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sample();
    adv();
  endtask

  // Words read from the FIFO but never delivered were dropped by flush/reset.
  task automatic discard(input int g, input int expn, input string name);
    check(name, 32'(rd_cnt[g] - pop_cnt[g]), 32'(expn));
    repeat (rd_cnt[g] - pop_cnt[g]) begin
      if (g == 0) void'(q0.pop_front());
      else        void'(q1.pop_front());
    end
    pop_cnt[g] = rd_cnt[g];
  endtask

  task automatic drain(input int g, input string name);
    m_ready[g] = 1'b1;
    for (int n = 0; n < 100 && (qsize(g) != 0 || m_valid[g] === 1'b1); n++) tick();
    check(name, 32'(qsize(g)), 32'd0);
    m_ready[g] = 1'b0;
  endtask

  initial begin
    vec_t vt[11];
    int   pulses, p0;

    vt = '{'{1'b1, 1'b1, 1'b0, 16'h0000}, '{1'b1, 1'b1, 1'b0, 16'h0000},
           '{1'b1, 1'b1, 1'b1, 16'h0001}, '{1'b1, 1'b1, 1'b1, 16'h0002},
           '{1'b1, 1'b1, 1'b1, 16'h0003}, '{1'b1, 1'b1, 1'b1, 16'h0004},
           '{1'b1, 1'b1, 1'b1, 16'h0005}, '{1'b1, 1'b1, 1'b1, 16'h0006},
           '{1'b1, 1'b0, 1'b1, 16'h0007}, '{1'b1, 1'b0, 1'b1, 16'h0008},
           '{1'b1, 1'b0, 1'b0, 16'h0000}};

    rst_n   = 1'b0;
    m_ready = 2'b00;
    flush   = 2'b00;
    adv();
    adv();
    sample();
    for (int g = 0; g < 2; g++) begin
      check($sformatf("rst_valid%0d", g), 32'(m_valid[g]), 32'd0);
      check($sformatf("rst_rd_en%0d", g), 32'(rd_en[g]), 32'd0);
      check($sformatf("rst_busy%0d", g), 32'(busy[g]), 32'd0);
      check($sformatf("rst_data%0d", g), 32'(sdata(g)), 32'd0);
    end
`ifdef HS_FIFO_SFIFO_RD_STREAM_PKT_CNT_EN
    check("rst_pkt_cnt", pkt_cnt0, 32'd0);
`endif
    adv();
    rst_n = 1'b1;
    tick();

    // Latency 1, full throughput, cycle-exact table.
    for (int i = 1; i <= 8; i++) load(0, 16'(i), 1'b0);
    for (int c = 0; c < 11; c++) begin
      m_ready[0] = vt[c].rdy;
      sample();
      check($sformatf("t1_rd_en[%0d]", c), 32'(rd_en[0]), 32'(vt[c].exp_rd));
      check($sformatf("t1_valid[%0d]", c), 32'(m_valid[0]), 32'(vt[c].exp_vld));
      if (vt[c].exp_vld) check($sformatf("t1_data[%0d]", c), 32'(m_data0), 32'(vt[c].exp_dat));
      adv();
    end
    m_ready[0] = 1'b0;
    check("t1_drained", 32'(q0.size()), 32'd0);

    // Latency 2, ready toggling.
    p0 = pop_cnt[1];
    for (int i = 1; i <= 8; i++) load(1, 16'h0100 + 16'(i), (i == 4 || i == 8));
    for (int n = 0; n < 60 && pop_cnt[1] - p0 < 8; n++) begin
      m_ready[1] = (n % 2 == 0);
      tick();
    end
    m_ready[1] = 1'b0;
    check("t2_words", 32'(pop_cnt[1] - p0), 32'd8);
    check("t2_queue", 32'(q1.size()), 32'd0);

    // Backpressure: ready low for 10 cycles.
    pulses = 0;
    for (int i = 1; i <= 8; i++) load(1, 16'(i), 1'b0);
    for (int n = 0; n < 10; n++) begin
      sample();
      if (rd_en[1] === 1'b1) pulses++;
      if (m_valid[1] === 1'b1) check($sformatf("t3_hold[%0d]", n), 32'(m_data1), 32'h0001);
      if (n == 9) begin
        check("t3_rd_en_end", 32'(rd_en[1]), 32'd0);
        check("t3_valid_end", 32'(m_valid[1]), 32'd1);
      end
      adv();
    end
    check("t3_pulses", 32'(pulses), 32'd3);
    drain(1, "t3_drain");

    // Flush with two words in flight and one buffered.
    for (int i = 1; i <= 8; i++) load(1, 16'h0200 + 16'(i), 1'b0);
    repeat (3) tick();
    flush[1] = 1'b1;
    sample();
    check("t4_valid_at_flush", 32'(m_valid[1]), 32'd1);
    check("t4_rd_en_at_flush", 32'(rd_en[1]), 32'd0);
    adv();
    flush[1] = 1'b0;
    for (int n = 0; n < 2; n++) begin
      sample();
      check($sformatf("t4_valid[%0d]", n), 32'(m_valid[1]), 32'd0);
      check($sformatf("t4_busy[%0d]", n), 32'(busy[1]), 32'd1);
      check($sformatf("t4_rd_en[%0d]", n), 32'(rd_en[1]), 32'd0);
      adv();
    end
    discard(1, 3, "t4_discarded");
    sample();
    check("t4_busy_end", 32'(busy[1]), 32'd0);
    check("t4_rd_en_resume", 32'(rd_en[1]), 32'd1);
    adv();
    drain(1, "t4_drain");

    // Packets of length 1/4/2 on the last-enabled instance.
    for (int i = 0; i < 7; i++) load(0, 16'h0400 + 16'(i + 1), (i == 0 || i == 4 || i == 6));
    drain(0, "t5_drain");
`ifdef HS_FIFO_SFIFO_RD_STREAM_PKT_CNT_EN
    check("t5_pkt_cnt", pkt_cnt0, 32'd3);
`endif
    flush[0] = 1'b1;
    tick();
    flush[0] = 1'b0;
    sample();
    check("t5_busy", 32'(busy[0]), 32'd1);
`ifdef HS_FIFO_SFIFO_RD_STREAM_PKT_CNT_EN
    check("t5_pkt_cnt_flush", pkt_cnt0, 32'd0);
`endif
    adv();
    sample();
    check("t5_busy_end", 32'(busy[0]), 32'd0);
    adv();
    discard(0, 0, "t5_discarded");

    // Reset mid-stream with three words buffered.
    for (int i = 1; i <= 8; i++) load(1, 16'h0300 + 16'(i), 1'b0);
    repeat (5) tick();
    rst_n = 1'b0;
    sample();
    check("t6_valid_pre", 32'(m_valid[1]), 32'd1);
    check("t6_rd_en_in_rst", 32'(rd_en[1]), 32'd0);
    adv();
    sample();
    for (int g = 0; g < 2; g++) begin
      check($sformatf("t6_valid%0d", g), 32'(m_valid[g]), 32'd0);
      check($sformatf("t6_data%0d", g), 32'(sdata(g)), 32'd0);
      check($sformatf("t6_last%0d", g), 32'(m_last[g]), 32'd0);
      check($sformatf("t6_busy%0d", g), 32'(busy[g]), 32'd0);
      check($sformatf("t6_rd_en%0d", g), 32'(rd_en[g]), 32'd0);
    end
    adv();
    rst_n = 1'b1;
    discard(1, 3, "t6_discarded");
    p0 = pop_cnt[1];
    drain(1, "t6_drain");
    check("t6_resumed_words", 32'(pop_cnt[1] - p0), 32'd5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
